// File: rtl/dpram_fifo_pkg.sv
// Shared defaults for the dual-port-RAM FIFO controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dpram_fifo_pkg;

  // Default geometry matches the double_ram build: 4-bit words, 8 locations.
  localparam int DFLT_DATA_W = 4;
  localparam int DFLT_ADDR_W = 3;
  localparam int DFLT_RD_LAT = 1;
  localparam int DEPTH       = 1 << DFLT_ADDR_W;

  // Width of the optional overflow/underflow event counters.
  localparam int ERR_CNT_W   = 8;

endpackage : dpram_fifo_pkg

// File: rtl/dpram_fifo_ptr.sv
// Wrap-around pointer: W-bit counter with increment enable and synchronous clear.
// Latency: o_ptr updates on the edge after i_inc; o_ptr_nxt is the combinational next value.
// Backpressure: none; the caller only raises i_inc for accepted transfers.
//
// Ports
//   clock      in   clock, rising edge
//   i_clr      in   synchronous clear (has priority over i_inc)
//   i_inc      in   advance pointer by one
//   o_ptr      out  current pointer value
//   o_ptr_nxt  out  value o_ptr takes on the next rising edge
module dpram_fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr,
  output logic [W-1:0] o_ptr_nxt
);

  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_nxt;

  // The extra MSB above the RAM address bits toggles on every wrap, which is
  // what lets the top tell full from empty when the low bits match.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_clr) begin
      w_ptr_nxt = '0;
    end else if (i_inc) begin
      w_ptr_nxt = r_ptr + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    r_ptr <= w_ptr_nxt;
  end

  assign o_ptr     = r_ptr;
  assign o_ptr_nxt = w_ptr_nxt;

endmodule : dpram_fifo_ptr

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM (write port + read port, single clock).
// Latency: push writes the RAM on the accepting edge; popped word valid RAM_RD_LAT cycles after rd_en is sampled.
// Backpressure: push dropped while full, pop dropped while empty; the requester must hold and retry.
//
// Optional build macro: DPRAM_FIFO_ERR_CNT_EN adds saturating ovf_cnt/udf_cnt outputs.
//
// Ports
//   clock, rst_n           single clock; synchronous active-low reset
//   wr_en, wr_data, full   push side; full is registered
//   rd_en, rd_data,        pop side; rd_data is the RAM q, qualified by rd_valid;
//   rd_valid, empty        empty is registered
//   level                  registered word count, 0..2**ADDR_W
//   ram_wren, ram_wraddress, ram_data, ram_rdaddress, ram_q   RAM connections
//   ovf_cnt, udf_cnt       rejected push / pop counters (macro builds only)
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_W     = DFLT_DATA_W,
  parameter int ADDR_W     = DFLT_ADDR_W,
  parameter int RAM_RD_LAT = DFLT_RD_LAT   // fixed by the RAM build, 1..3
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [DATA_W-1:0] ram_q
`ifdef DPRAM_FIFO_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] ovf_cnt,
  output logic [ERR_CNT_W-1:0] udf_cnt
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0]         w_wr_ptr, w_wr_nxt;
  logic [PW-1:0]         w_rd_ptr, w_rd_nxt;
  logic                  w_push_acc, w_pop_acc;
  logic                  r_full, r_empty;
  logic [PW-1:0]         r_level;
  logic [RAM_RD_LAT-1:0] r_vld_sr;

  // Accept decisions use the flags as registered at the start of the cycle.
  // Both are gated by rst_n so no RAM strobe or pointer move happens on a
  // reset edge, including a push arriving together with reset.
  assign w_push_acc = rst_n & wr_en & ~r_full;
  assign w_pop_acc  = rst_n & rd_en & ~r_empty;

  dpram_fifo_ptr #(.W(PW)) u_wr_ptr (
    .clock     (clock),
    .i_clr     (~rst_n),
    .i_inc     (w_push_acc),
    .o_ptr     (w_wr_ptr),
    .o_ptr_nxt (w_wr_nxt)
  );

  dpram_fifo_ptr #(.W(PW)) u_rd_ptr (
    .clock     (clock),
    .i_clr     (~rst_n),
    .i_inc     (w_pop_acc),
    .o_ptr     (w_rd_ptr),
    .o_ptr_nxt (w_rd_nxt)
  );

  // Flags are computed from the next pointer values so that they are true
  // registers yet already reflect this cycle's accepted push/pop.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_level <= '0;
    end else begin
      r_empty <= (w_wr_nxt == w_rd_nxt);
      r_full  <= (w_wr_nxt[ADDR_W] != w_rd_nxt[ADDR_W]) &&
                 (w_wr_nxt[ADDR_W-1:0] == w_rd_nxt[ADDR_W-1:0]);
      r_level <= w_wr_nxt - w_rd_nxt;
    end
  end

  // The accept flag walks through a RAM_RD_LAT-deep shift so rd_valid lines
  // up with the RAM's q for the address presented on the accepting edge.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr <= (r_vld_sr << 1) | RAM_RD_LAT'(w_pop_acc);
    end
  end

`ifdef DPRAM_FIFO_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_ovf_cnt, r_udf_cnt;

  // Saturating counts of requests dropped for lack of space / data.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
      r_udf_cnt <= '0;
    end else begin
      if (wr_en && r_full && (r_ovf_cnt != '1)) begin
        r_ovf_cnt <= r_ovf_cnt + ERR_CNT_W'(1);
      end
      if (rd_en && r_empty && (r_udf_cnt != '1)) begin
        r_udf_cnt <= r_udf_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign udf_cnt = r_udf_cnt;
`endif

  assign full          = r_full;
  assign empty         = r_empty;
  assign level         = r_level;
  assign rd_valid      = r_vld_sr[RAM_RD_LAT-1];
  assign rd_data       = ram_q;
  assign ram_wren      = w_push_acc;
  assign ram_wraddress = w_wr_ptr[ADDR_W-1:0];
  assign ram_data      = wr_data;
  assign ram_rdaddress = w_rd_ptr[ADDR_W-1:0];

endmodule : dpram_fifo_ctrl

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 1-cycle-latency dual-port RAM.
// Latency: each table row is one clock; strobes checked before the edge, flags after it.
// Backpressure: rows cover full/empty rejection, simultaneous push+pop, wrap and mid-stream reset.
module tb_dpram_fifo_ctrl;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       full;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [3:0] level;
  logic       ram_wren;
  logic [2:0] ram_wraddress;
  logic [3:0] ram_data;
  logic [2:0] ram_rdaddress;
  logic [3:0] ram_q;
`ifdef DPRAM_FIFO_ERR_CNT_EN
  logic [7:0] ovf_cnt;
  logic [7:0] udf_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clock = ~clock;

  dpram_fifo_ctrl dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .level         (level),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_rdaddress (ram_rdaddress),
    .ram_q         (ram_q)
`ifdef DPRAM_FIFO_ERR_CNT_EN
    ,
    .ovf_cnt       (ovf_cnt),
    .udf_cnt       (udf_cnt)
`endif
  );

  // double_ram stand-in: registered read, one cycle from rdaddress to q.
  logic [3:0] mem [8];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  typedef struct {
    bit         rst_n;
    bit         wr_en;
    logic [3:0] wr_data;
    bit         rd_en;
    bit         e_wren;
    logic [2:0] e_waddr;
    logic [2:0] e_raddr;
    logic [3:0] e_level;
    bit         e_full;
    bit         e_empty;
    bit         e_rdv;
    logic [3:0] e_rdata;
    logic [7:0] e_ovf;
    logic [7:0] e_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit we, int wd, bit re,
                              bit ewren, int ewa, int era, int elev,
                              bit efull, bit eempty, bit erdv, int erd,
                              int eovf, int eudf);
    vec_t v;
    v.rst_n   = rst;
    v.wr_en   = we;
    v.wr_data = 4'(wd);
    v.rd_en   = re;
    v.e_wren  = ewren;
    v.e_waddr = 3'(ewa);
    v.e_raddr = 3'(era);
    v.e_level = 4'(elev);
    v.e_full  = efull;
    v.e_empty = eempty;
    v.e_rdv   = erdv;
    v.e_rdata = 4'(erd);
    v.e_ovf   = 8'(eovf);
    v.e_udf   = 8'(eudf);
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Vector table. W[n] = (n+1)&15 during the steady-state phase.
    // 1: fill with 7..0
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 1, 7 - i, 0, 1, i, 0, i + 1, i == 7, 0, 0, 0, 0, 0));
    // 2: push while full is dropped
    vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1, 0));
    // 3: drain; data returns one cycle after each pop
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, j, 7 - j, 0, j == 7, 1, 7 - j, 1, 0));
    // 4: push+pop while empty, then pop the new word
    vecs.push_back(mk(1, 1, 9, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 9, 1, 1));
    // 5: prime to level 4, then 20 cycles of push+pop through two wraps
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, i + 1, 0, 1, 1 + i, 1, i + 1, 0, 0, 0, 0, 1, 1));
    for (int k = 0; k < 20; k++)
      vecs.push_back(mk(1, 1, (k + 5) & 15, 1, 1, (5 + k) % 8, (1 + k) % 8, 4, 0, 0, 1, (k + 1) & 15, 1, 1));
    // 6: reach level 5 with a pop in flight, then reset mid-stream
    vecs.push_back(mk(1, 1, 9, 0, 1, 1, 5, 5, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 10, 1, 1, 2, 5, 5, 0, 0, 1, 5, 1, 1));
    vecs.push_back(mk(0, 1, 11, 1, 0, 3, 6, 0, 0, 1, 0, 0, 0, 0));
    // after reset: pop on empty dropped, pointers restart at address 0
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 12, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 12, 0, 1));

    // Initial reset for 20 cycles with a push held high: nothing may reach the RAM.
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 4'hF;
    rd_en   = 1'b1;
    repeat (20) @(posedge clock);
    @(negedge clock);
    chk("reset_wren",  -1, 32'(ram_wren), 0);
    chk("reset_level", -1, 32'(level),    0);
    chk("reset_empty", -1, 32'(empty),    1);
    chk("reset_full",  -1, 32'(full),     0);
    chk("reset_rdv",   -1, 32'(rd_valid), 0);
    chk("reset_waddr", -1, 32'(ram_wraddress), 0);
`ifdef DPRAM_FIFO_ERR_CNT_EN
    chk("reset_ovf",   -1, 32'(ovf_cnt), 0);
    chk("reset_udf",   -1, 32'(udf_cnt), 0);
`endif

    foreach (vecs[r]) begin
      rst_n   = vecs[r].rst_n;
      wr_en   = vecs[r].wr_en;
      wr_data = vecs[r].wr_data;
      rd_en   = vecs[r].rd_en;
      #1;
      chk("ram_wren",      r, 32'(ram_wren),      32'(vecs[r].e_wren));
      chk("ram_wraddress", r, 32'(ram_wraddress), 32'(vecs[r].e_waddr));
      chk("ram_rdaddress", r, 32'(ram_rdaddress), 32'(vecs[r].e_raddr));
      if (vecs[r].e_wren)
        chk("ram_data",    r, 32'(ram_data),      32'(vecs[r].wr_data));
      @(posedge clock);
      #1;
      chk("level",    r, 32'(level),    32'(vecs[r].e_level));
      chk("full",     r, 32'(full),     32'(vecs[r].e_full));
      chk("empty",    r, 32'(empty),    32'(vecs[r].e_empty));
      chk("rd_valid", r, 32'(rd_valid), 32'(vecs[r].e_rdv));
      if (vecs[r].e_rdv)
        chk("rd_data", r, 32'(rd_data), 32'(vecs[r].e_rdata));
`ifdef DPRAM_FIFO_ERR_CNT_EN
      chk("ovf_cnt", r, 32'(ovf_cnt), 32'(vecs[r].e_ovf));
      chk("udf_cnt", r, 32'(udf_cnt), 32'(vecs[r].e_udf));
`endif
      @(negedge clock);
    end

    // Idle tail: the last pop's strobe must last exactly one cycle.
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clock);
    #1;
    chk("tail_rdv",   -2, 32'(rd_valid), 0);
    chk("tail_empty", -2, 32'(empty),    1);
    chk("tail_level", -2, 32'(level),    0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dpram_fifo_ctrl
